bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter. It sits directly upstream of the 4-digit 7-segment display path.
- Accepts a 32-bit binary value through a valid/ready handshake.
- Converts it with iterative shift-add-3 (double dabble), one bit per cycle.
- Presents four registered decimal digits, a one-cycle completion strobe, and an overflow flag for values above 9999.

---
 rtl/bin2bcd_seq_pkg.sv | 22 ++
 rtl/bin2bcd_seq_bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 137 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int CONV_BITS = 14;
    localparam int MAX_VALUE = 9999;
    localparam int NIB_W     = 4;
    localparam int NUM_DIG   = 4;
    localparam int BCD_W     = NIB_W * NUM_DIG;
    localparam int CNT_W     = $clog2(CONV_BITS + 1);

    localparam logic [NIB_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [NIB_W-1:0] ADD3_CONST  = 4'd3;
    localparam logic [BCD_W-1:0] BCD_SAT     = 16'h9999;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + ADD3_CONST : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
// Optional leading-zero blank flags are enabled by defining BCD_BLANK_ZERO_EN.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] valor,
    output logic [3:0]          dig1,
    output logic [3:0]          dig2,
    output logic [3:0]          dig3,
    output logic [3:0]          dig4,
    output logic                out_valid,
    output logic                overflow
`ifdef BCD_BLANK_ZERO_EN
    ,
    output logic [3:0]          blank
`endif
);

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  val_q, val_d;
    logic [CONV_BITS-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [BCD_W-1:0]     dig_q, dig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 ovf_q, ovf_d;

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[g*NIB_W +: NIB_W]),
            .nib_o (bcd_adj[g*NIB_W +: NIB_W])
        );
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d   = valor;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (val_q > IN_WIDTH'(MAX_VALUE)) begin
                    bcd_d   = BCD_SAT;
                    pend_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    bin_d   = val_q[CONV_BITS-1:0];
                    bcd_d   = '0;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Top bit of the thousands nibble falls off; unreachable for values <= 9999.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CONV_BITS - 1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Digits are captured on entry to DONE so they are valid alongside out_valid.
        if (state_d == DONE) begin
            dig_d = bcd_d;
            ovf_d = pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dig1      = dig_q[3:0];
    assign dig2      = dig_q[7:4];
    assign dig3      = dig_q[11:8];
    assign dig4      = dig_q[15:12];
    assign overflow  = ovf_q;

`ifdef BCD_BLANK_ZERO_EN
    logic [3:0] blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (state_d == DONE) begin
            blank_d[0] = 1'b0;
            blank_d[3] = (bcd_d[15:12] == 4'd0);
            blank_d[2] = blank_d[3] && (bcd_d[11:8] == 4'd0);
            blank_d[1] = blank_d[2] && (bcd_d[7:4] == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_q <= 4'b0000;
        else        blank_q <= blank_d;
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus hand-written corner sequences.
module tb_bin2bcd_seq;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] valor    = 32'd0;
    logic        in_ready, out_valid, overflow;
    logic [3:0]  dig1, dig2, dig3, dig4;
`ifdef BCD_BLANK_ZERO_EN
    logic [3:0]  blank;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .valor     (valor),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .dig4      (dig4),
        .out_valid (out_valid),
        .overflow  (overflow)
`ifdef BCD_BLANK_ZERO_EN
        ,
        .blank     (blank)
`endif
    );

    typedef struct {
        logic [31:0] v;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        int   x;
        if (v > 32'd9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            x     = int'(v);
            e.bcd = {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
            e.ovf = 1'b0;
        end
        e.blank    = 4'b0000;
        e.blank[3] = (e.bcd[15:12] == 4'd0);
        e.blank[2] = e.blank[3] && (e.bcd[11:8] == 4'd0);
        e.blank[1] = e.blank[2] && (e.bcd[7:4] == 4'd0);
        return e;
    endfunction

    // Scoreboard consumer: every completion must match the oldest accepted value.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 required none pending at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("digits", {16'd0, dig4, dig3, dig2, dig1}, {16'd0, e.bcd});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
`ifdef BCD_BLANK_ZERO_EN
                chk("blank", {28'd0, blank}, {28'd0, e.blank});
`endif
            end
        end
    end

    // Entered at the sample point of cycle 1; returns at the sample where out_valid is seen.
    task automatic wait_done(input int exp_lat, input bit poke);
        bit seen;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                chk("latency", 32'(k), 32'(exp_lat));
                seen = 1'b1;
                break;
            end
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (poke && k == 5) begin
                in_valid = 1'b1;
                valor    = 32'd8888;
            end
            if (poke && k == 6) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got no out_valid required one within 40 cycles");
        end
    endtask

    task automatic send(input logic [31:0] v, input exp_t e, input bit hold, input bit poke);
        int t;
        t = 0;
        @(negedge clk);
        valor    = v;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) begin
            in_valid = 1'b0;
            valor    = $urandom;
        end
        wait_done(e.ovf ? 2 : 16, poke);
    endtask

    vec_t tbl[12];

    initial begin
        exp_t e;
        int   t;

        tbl[0]  = '{32'd1234,       16'h1234, 1'b0, 4'b0000};
        tbl[1]  = '{32'd0,          16'h0000, 1'b0, 4'b1110};
        tbl[2]  = '{32'd9999,       16'h9999, 1'b0, 4'b0000};
        tbl[3]  = '{32'd10000,      16'h9999, 1'b1, 4'b0000};
        tbl[4]  = '{32'hFFFF_FFFF,  16'h9999, 1'b1, 4'b0000};
        tbl[5]  = '{32'd7,          16'h0007, 1'b0, 4'b1110};
        tbl[6]  = '{32'd42,         16'h0042, 1'b0, 4'b1100};
        tbl[7]  = '{32'd1000,       16'h1000, 1'b0, 4'b0000};
        tbl[8]  = '{32'd16383,      16'h9999, 1'b1, 4'b0000};
        tbl[9]  = '{32'd9990,       16'h9990, 1'b0, 4'b0000};
        tbl[10] = '{32'd10,         16'h0010, 1'b0, 4'b1100};
        tbl[11] = '{32'd305,        16'h0305, 1'b0, 4'b1000};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_digits", {16'd0, dig4, dig3, dig2, dig1}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BCD_BLANK_ZERO_EN
        chk("rst_blank", {28'd0, blank}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            e.bcd   = tbl[i].bcd;
            e.ovf   = tbl[i].ovf;
            e.blank = tbl[i].blank;
            send(tbl[i].v, e, 1'b0, 1'b0);
        end

        // Back-to-back with in_valid held: second accept lands on cycle 17.
        send(32'd0, model(32'd0), 1'b1, 1'b0);
        valor = 32'd9999;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_cycle17", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        sb.push_back(model(32'd9999));
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(16, 1'b0);

        // valor change and in_valid pulse mid-conversion are ignored.
        send(32'd321, model(32'd321), 1'b0, 1'b1);

        // Reset in cycle 8 of a conversion of 5678: no completion expected.
        @(negedge clk);
        valor    = 32'd5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", {16'd0, dig4, dig3, dig2, dig1}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BCD_BLANK_ZERO_EN
        chk("mid_rst_blank", {28'd0, blank}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(32'd42, model(32'd42), 1'b0, 1'b0);

        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
